bullet_collision_scanner: RTL and testbench
===========================================

# bullet_collision_scanner

Frame-rate collision engine for the battle box. On each `start` pulse it walks the bullet table through the bullet store's collision-side read port, one bullet per clock. Each bullet is tested against the player heart's bounding box and applies colour-dependent damage or healing to the player HP register. The scan ends with a keep-render mask and a one-cycle `isComplete` pulse back to the bullet store.

## Interface
Parameters:
- `N_BULLET`, 3: number of bullet slots scanned, indices 0..N_BULLET-1.
- `INDEX_W`, 3: width of the bullet index bus.
- `HP_MAX`, 20: HP value loaded at reset and while not running.
- `DMG`, 1: HP lost per damaging hit.
- `HEAL`, 1: HP gained per green hit.

Ports:
- `clk`, input, 1: system clock; every state change happens on its rising edge.
- `reset`, input, 1: asynchronous reset, active-high.
- `isRun`, input, 1: battle active; low forces idle and reloads HP.
- `start`, input, 1: scan request, sampled only in IDLE.
- `playerPos`, input, 16: player position, [15:8] = x, [7:0] = y.
- `playerSize`, input, 16: player size, [15:8] = width, [7:0] = height.
- `playerMoving`, input, 1: player moved this frame; gates blue damage.
- `index`, output, INDEX_W: bullet slot currently addressed on the store's collision port.
- `position`, input, 16: bullet position of `index`, combinational from the store; [15:8] = x, [7:0] = y.
- `size`, input, 16: bullet size of `index`; [15:8] = width, [7:0] = height.
- `color`, input, 2: bullet colour; 00 = white, 01 = green, 10 = blue, 11 = inert.
- `isRender`, input, 1: bullet currently alive.
- `indexCollide`, output, N_BULLET: keep-render mask; bit i = 1 means bullet i stays visible.
- `isComplete`, output, 1: one-cycle pulse; `indexCollide` is valid.
- `hp`, output, 8: current player HP.
- `isDead`, output, 1: high when `hp` == 0.
- `busy`, output, 1: high in SCAN and DONE.

## Operation
- FSM states are IDLE, SCAN and DONE.
  - IDLE: if `start` is high at an edge, clear the shadow mask, set idx = 0 and go to SCAN.
  - SCAN: `index` = idx. At each edge, register the result for bullet idx. If idx == N_BULLET-1, go to DONE; otherwise increment idx.
  - DONE: copy the shadow mask to `indexCollide`; `isComplete` = 1 for this cycle only. Go to IDLE on the next edge.
- Hit test is axis-aligned overlap with strict inequalities:
  - bx < px+pw, px < bx+bw, by < py+ph and py < by+bh.
  - All sums are 9-bit unsigned, so there is no wrap.
  - Touching edges are not a hit. A zero width or zero height never hits.
- hit = `isRender` AND overlap.
- shadow[idx] = `isRender` AND NOT hit. Dead bullets stay dead.
- HP effect, applied on the same edge as the hit is registered:
  - white: hp = max(hp-DMG, 0).
  - green: hp = min(hp+HEAL, HP_MAX).
  - blue: damage as white only when `playerMoving` = 1; otherwise no change.
  - inert: no HP change, but the bullet is still removed from the mask.
- `isRun` low, synchronously at any state: FSM goes to IDLE, idx = 0, `hp` = HP_MAX, `indexCollide` = all ones, and no `isComplete` is produced. A scan aborted this way produces no pulse.
- `start` is ignored in SCAN and DONE. It is not queued.
- `isDead` is combinational from `hp`. HP updates continue at 0 (healing can revive).
- `index` in IDLE and DONE is 0.

## Timing
- Reset values:
  - state IDLE, idx 0, `index` 0.
  - `hp` HP_MAX, `isDead` 0.
  - `indexCollide` all ones.
  - `isComplete` 0, `busy` 0.
- Latency:
  - `start` sampled at edge E0.
  - Bullet i is evaluated during the cycle after E(i), and its result is registered at edge E(i+1).
  - `isComplete` is high from E(N_BULLET) to E(N_BULLET+1).
  - Total is N_BULLET+2 cycles from `start` to IDLE (5 for the default).
- The store's outputs must settle within the cycle that `index` is driven; the store is combinational-read.
- `indexCollide` changes only on entry to DONE (or on reset / `isRun` low) and holds between scans.
- `start` asserted on the edge where DONE exits to IDLE is not sampled. The earliest accepted restart is the following edge.

## Test plan
- Player (100,100) 16x16; bullet 0 white (105,110) 16x16 rendered; bullets 1 and 2 far away and rendered; `start` pulse → `isComplete` at cycle 4, `indexCollide` = 3'b110, `hp` 20→19.
- Bullet 0 at (116,100) 16x16, touching the player's right edge exactly → no hit, `indexCollide` = 3'b111, `hp` unchanged.
- Blue bullet overlapping: `playerMoving` = 0 → `hp` unchanged but mask bit cleared; repeat with `playerMoving` = 1 → `hp` drops by 1.
- `hp` = 20 with a green hit → stays 20. `hp` = 1 with two white hits in one scan → 0, `isDead` = 1, no underflow.
- Pulse `start` mid-scan → ignored, single `isComplete`. Drop `isRun` during SCAN → IDLE next edge, no `isComplete`, `hp` = 20, mask 3'b111.
- Assert `reset` asynchronously mid-scan → all outputs return to their reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/bullet_collision_scanner_if.sv
// bullet_collision_scanner_if: collision-side read port between the scanner and the bullet store.
interface bullet_collision_scanner_if #(
    parameter int N_BULLET = 3,
    parameter int INDEX_W  = 3
);
    logic [INDEX_W-1:0]  index;
    logic [15:0]         position;
    logic [15:0]         size;
    logic [1:0]          color;
    logic                isRender;
    logic [N_BULLET-1:0] indexCollide;
    logic                isComplete;
    modport master (output index, indexCollide, isComplete, input position, size, color, isRender);
    modport slave  (input index, indexCollide, isComplete, output position, size, color, isRender);
endinterface

// File: rtl/bullet_collision_scanner.sv
// bullet_collision_scanner: per-frame scan of the bullet table against the player heart,
// applying colour-dependent HP effects and producing a keep-render mask.
module bullet_collision_scanner #(
    parameter int N_BULLET = 3,
    parameter int INDEX_W  = 3,
    parameter int HP_MAX   = 20,
    parameter int DMG      = 1,
    parameter int HEAL     = 1
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   isRun,
    input  logic                                   start,
    input  logic [15:0]                            playerPos,
    input  logic [15:0]                            playerSize,
    input  logic                                   playerMoving,
    bullet_collision_scanner_if.master             bus,
    output logic [7:0]                             hp,
    output logic                                   isDead,
    output logic                                   busy
);
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
    state_t              state_q, state_d;
    logic [INDEX_W-1:0]  idx_q, idx_d;
    logic [7:0]          hp_q, hp_d;
    logic [N_BULLET-1:0] shadow_q, shadow_d, mask_q, mask_d, sel;
    logic [8:0]          px, py, pw, ph, bx, by, bw, bh, heal_sum;
    logic [7:0]          dmg_hp, heal_hp, hp_eff;
    logic                overlap, hit, keep, last;

    assign px = {1'b0, playerPos[15:8]};
    assign py = {1'b0, playerPos[7:0]};
    assign pw = {1'b0, playerSize[15:8]};
    assign ph = {1'b0, playerSize[7:0]};
    assign bx = {1'b0, bus.position[15:8]};
    assign by = {1'b0, bus.position[7:0]};
    assign bw = {1'b0, bus.size[15:8]};
    assign bh = {1'b0, bus.size[7:0]};
    // Empty boxes are excluded explicitly: strict overlap alone would accept a zero-width sliver inside the player.
    assign overlap = (bw != 0) && (bh != 0) && (pw != 0) && (ph != 0) &&
                     (bx < px + pw) && (px < bx + bw) && (by < py + ph) && (py < by + bh);
    assign hit  = bus.isRender && overlap;
    assign keep = bus.isRender && !hit;
    assign sel  = N_BULLET'(1) << idx_q;
    assign last = idx_q == INDEX_W'(N_BULLET - 1);

    assign dmg_hp   = hp_q >= 8'(DMG) ? hp_q - 8'(DMG) : 8'd0;
    assign heal_sum = {1'b0, hp_q} + 9'(HEAL);
    assign heal_hp  = heal_sum > 9'(HP_MAX) ? 8'(HP_MAX) : heal_sum[7:0];
    assign hp_eff   = bus.color == 2'b00 ? dmg_hp :
                      bus.color == 2'b01 ? heal_hp :
                      (bus.color == 2'b10 && playerMoving) ? dmg_hp : hp_q;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        hp_d     = hp_q;
        shadow_d = shadow_q;
        mask_d   = mask_q;
        case (state_q)
            IDLE: if (start) begin
                state_d  = SCAN;
                idx_d    = '0;
                shadow_d = '0;
            end
            SCAN: begin
                shadow_d = shadow_q | (keep ? sel : '0);
                hp_d     = hit ? hp_eff : hp_q;
                idx_d    = last ? '0 : idx_q + 1'b1;
                state_d  = last ? DONE : SCAN;
                mask_d   = last ? shadow_d : mask_q;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (!isRun) begin
            state_d = IDLE;
            idx_d   = '0;
            hp_d    = 8'(HP_MAX);
            mask_d  = '1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            hp_q     <= 8'(HP_MAX);
            shadow_q <= '0;
            mask_q   <= '1;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            hp_q     <= hp_d;
            shadow_q <= shadow_d;
            mask_q   <= mask_d;
        end
    end

    assign bus.index        = state_q == SCAN ? idx_q : '0;
    assign bus.indexCollide = mask_q;
    assign bus.isComplete   = state_q == DONE;
    assign hp               = hp_q;
    assign isDead           = hp_q == 8'd0;
    assign busy             = state_q != IDLE;
endmodule

// File: tb/tb_bullet_collision_scanner.sv
// tb_bullet_collision_scanner: directed vectors against a combinational bullet-store model.
module tb_bullet_collision_scanner;
    logic        clk = 1'b0;
    logic        reset, isRun, start, playerMoving;
    logic [15:0] playerPos, playerSize;
    logic [7:0]  hp;
    logic        isDead, busy;
    logic [15:0] pos_m[8], sz_m[8];
    logic [1:0]  col_m[8];
    logic        ren_m[8];
    int          n_checks = 0, n_errors = 0;

    bullet_collision_scanner_if #(.N_BULLET(3), .INDEX_W(3)) bif ();

    assign bif.position = pos_m[bif.index];
    assign bif.size     = sz_m[bif.index];
    assign bif.color    = col_m[bif.index];
    assign bif.isRender = ren_m[bif.index];

    bullet_collision_scanner dut (
        .clk(clk), .reset(reset), .isRun(isRun), .start(start),
        .playerPos(playerPos), .playerSize(playerSize), .playerMoving(playerMoving),
        .bus(bif), .hp(hp), .isDead(isDead), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_b(input int i, input logic [7:0] x, y, w, h, input logic [1:0] c, input logic r);
        pos_m[i] = {x, y};
        sz_m[i]  = {w, h};
        col_m[i] = c;
        ren_m[i] = r;
    endtask

    task automatic run_scan(input string tag, input logic [2:0] exp_mask, input logic [7:0] exp_hp);
        int k = 0;
        start = 1'b1;
        do begin
            @(posedge clk); #1;
            k++;
            if (k == 1) start = 1'b0;
            if (k <= 3) check({tag, " index"}, bif.index, k - 1);
        end while (!bif.isComplete && k < 10);
        check({tag, " complete_cycle"}, k, 4);
        check({tag, " mask"}, bif.indexCollide, exp_mask);
        check({tag, " hp"}, hp, exp_hp);
        @(posedge clk); #1;
        check({tag, " pulse_end"}, {bif.isComplete, busy}, 0);
    endtask

    initial begin
        int pulses;
        reset = 1'b1; isRun = 1'b1; start = 1'b0; playerMoving = 1'b0;
        playerPos = {8'd100, 8'd100};
        playerSize = {8'd16, 8'd16};
        for (int i = 0; i < 8; i++) set_b(i, 8'd10, 8'd10, 8'd4, 8'd4, 2'b00, 1'b1);
        #8;
        check("rst hp", hp, 20);
        check("rst isDead", isDead, 0);
        check("rst mask", bif.indexCollide, 3'b111);
        check("rst isComplete", bif.isComplete, 0);
        check("rst busy", busy, 0);
        check("rst index", bif.index, 0);
        #4 reset = 1'b0;

        set_b(0, 8'd105, 8'd110, 8'd16, 8'd16, 2'b00, 1'b1);
        run_scan("white_hit", 3'b110, 19);
        set_b(0, 8'd116, 8'd100, 8'd16, 8'd16, 2'b00, 1'b1);
        run_scan("touch_edge", 3'b111, 19);
        set_b(0, 8'd105, 8'd110, 8'd16, 8'd16, 2'b10, 1'b1);
        run_scan("blue_still", 3'b110, 19);
        playerMoving = 1'b1;
        run_scan("blue_moving", 3'b110, 18);
        playerMoving = 1'b0;
        set_b(0, 8'd105, 8'd110, 8'd16, 8'd16, 2'b01, 1'b1);
        run_scan("green_19", 3'b110, 19);
        run_scan("green_20", 3'b110, 20);
        run_scan("green_clamp", 3'b110, 20);
        set_b(0, 8'd105, 8'd110, 8'd16, 8'd16, 2'b11, 1'b1);
        run_scan("inert", 3'b110, 20);
        set_b(0, 8'd105, 8'd110, 8'd16, 8'd16, 2'b00, 1'b0);
        set_b(1, 8'd105, 8'd105, 8'd0, 8'd8, 2'b00, 1'b1);
        run_scan("dead_zero_w", 3'b110, 20);

        set_b(0, 8'd105, 8'd110, 8'd16, 8'd16, 2'b00, 1'b1);
        set_b(1, 8'd100, 8'd100, 8'd16, 8'd16, 2'b00, 1'b1);
        set_b(2, 8'd90, 8'd90, 8'd11, 8'd11, 2'b00, 1'b1);
        for (int s = 0; s < 6; s++) run_scan("triple", 3'b000, 8'(17 - 3 * s));
        set_b(1, 8'd10, 8'd10, 8'd4, 8'd4, 2'b00, 1'b1);
        set_b(2, 8'd10, 8'd10, 8'd4, 8'd4, 2'b00, 1'b1);
        run_scan("hp_to_1", 3'b110, 1);
        set_b(1, 8'd100, 8'd100, 8'd16, 8'd16, 2'b00, 1'b1);
        run_scan("hp_to_0", 3'b100, 0);
        check("dead flag", isDead, 1);
        run_scan("no_underflow", 3'b100, 0);
        set_b(0, 8'd105, 8'd110, 8'd16, 8'd16, 2'b01, 1'b1);
        set_b(1, 8'd10, 8'd10, 8'd4, 8'd4, 2'b00, 1'b1);
        run_scan("revive", 3'b110, 1);
        check("revive isDead", isDead, 0);

        set_b(0, 8'd105, 8'd110, 8'd16, 8'd16, 2'b00, 1'b1);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        isRun = 1'b0;
        @(posedge clk); #1;
        check("abort busy", busy, 0);
        check("abort hp", hp, 20);
        check("abort mask", bif.indexCollide, 3'b111);
        isRun = 1'b1;
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            pulses += int'(bif.isComplete);
        end
        check("abort no_pulse", pulses, 0);

        set_b(0, 8'd10, 8'd10, 8'd4, 8'd4, 2'b00, 1'b1);
        start = 1'b1;
        pulses = 0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            pulses += int'(bif.isComplete);
            if (k == 4) check("held start single_pulse", pulses, 1);
            if (k == 5) check("restart not_sampled", busy, 0);
            if (k == 6) begin
                check("restart next_edge", busy, 1);
                start = 1'b0;
            end
        end
        check("held start total_pulses", pulses, 2);

        set_b(0, 8'd105, 8'd110, 8'd16, 8'd16, 2'b00, 1'b1);
        run_scan("pre_reset", 3'b110, 19);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        check("async hp", hp, 20);
        check("async mask", bif.indexCollide, 3'b111);
        check("async busy", busy, 0);
        check("async index", bif.index, 0);
        check("async isComplete", bif.isComplete, 0);
        #1 reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
